// File: rtl/bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_binary
// Purpose  : Multi-cycle packed-BCD to unsigned binary converter using
//            reverse double-dabble (shift right, subtract 3 from any
//            nibble >= 8). Operands containing a digit > 9 are flagged
//            with err and skip the conversion.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_binary #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       BCD_value [DIGITS-1:0],
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [BIN_W-1:0] binary_value
);

  localparam int                     c_BCD_W = 4 * DIGITS;
  localparam int                     c_CNT_W = $clog2(BIN_W);
  localparam logic [c_CNT_W-1:0]     c_LAST  = c_CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ADJUST = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_BCD_W-1:0] r_bcd;
  logic [BIN_W-1:0]   r_bin;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;        // error flag of the operand in flight
  logic               r_err_out;    // error flag presented to the consumer
  logic [BIN_W-1:0]   r_binary;

  logic [c_BCD_W-1:0] w_bcd_packed;
  logic [c_BCD_W-1:0] w_bcd_adj;
  logic [BIN_W-1:0]   w_bin_shift;
  logic               w_bad;

  // Flatten the digit array so digit 0 lands in the least significant nibble.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
      assign w_bcd_packed[4*gi +: 4] = BCD_value[gi];
    end
  endgenerate

  // Flag any operand digit outside 0..9.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (BCD_value[i] > 4'd9) w_bad = 1'b1;
    end
  end

  // Per-nibble correction after a shift: nibbles >= 8 lose 3, no inter-nibble borrow.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i+3]) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] - 4'd3;
    end
  end

  // Low bit of the BCD register falls into the MSB of the binary accumulator.
  assign w_bin_shift = {r_bcd[0], r_bin[BIN_W-1:1]};

  // Control FSM and datapath; results are captured on the edge entering FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_err_out <= 1'b0;
      r_binary  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad) begin
              r_err     <= 1'b1;
              r_bin     <= '0;
              r_err_out <= 1'b1;
              r_binary  <= '0;
              r_state   <= S_FINISH;
            end else begin
              r_bcd   <= w_bcd_packed;
              r_bin   <= '0;
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd <= {1'b0, r_bcd[c_BCD_W-1:1]};
          r_bin <= w_bin_shift;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_binary  <= w_bin_shift;
            r_err_out <= r_err;
            r_state   <= S_FINISH;
          end else begin
            r_state <= S_ADJUST;
          end
        end
        S_ADJUST: begin
          r_bcd   <= w_bcd_adj;
          r_state <= S_SHIFT;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready        = (r_state == S_IDLE);
  assign done         = (r_state == S_FINISH);
  assign err          = r_err_out;
  assign binary_value = r_binary;

`ifndef SYNTHESIS
  // A legal operand always drains the BCD register completely by the last shift.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_FINISH && !r_err) begin
      assert (r_bcd == '0)
        else $error("bcd_to_binary: residual BCD bits after conversion");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_binary
// Purpose  : Self-checking bench for bcd_to_binary: table of directed
//            operands plus hand-written multi-cycle sequences (start during
//            conversion, async reset mid-conversion, back-to-back starts).
//            Latencies count the accept edge as edge 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       bcd_in [DIGITS-1:0];
  logic             ready;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] binary_value;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .BCD_value    (bcd_in),
    .ready        (ready),
    .done         (done),
    .err          (err),
    .binary_value (binary_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      bcd;
    logic [BIN_W-1:0] exp_bin;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_bcd(input logic [31:0] v);
    for (int i = 0; i < DIGITS; i++) bcd_in[i] = v[4*i +: 4];
  endtask

  // Waits for IDLE, pulses start for one cycle, measures latency and checks results.
  task automatic run_convert(input logic [31:0] v, input logic [BIN_W-1:0] exp_bin,
                             input logic exp_err, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready before start", {31'd0, ready}, 32'd1);
    set_bcd(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_bcd(32'hFFFF_FFFF);
    n   = 1;
    lat = -1;
    while (n < 200) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1; n++;
    end
    check("latency", lat, exp_lat);
    check("binary_value", {5'd0, binary_value}, {5'd0, exp_bin});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("ready during done", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check("done width", {31'd0, done}, 32'd0);
    check("ready after done", {31'd0, ready}, 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    int n;
    int dcnt;
    int rcnt;
    int d1;
    int d2;

    vecs[0] = '{32'h1234_5678, 27'h0BC614E, 1'b0, 54};
    vecs[1] = '{32'h9999_9999, 27'h5F5E0FF, 1'b0, 54};
    vecs[2] = '{32'h0000_0000, 27'h0000000, 1'b0, 54};
    vecs[3] = '{32'h0000_A000, 27'h0000000, 1'b1, 1};
    vecs[4] = '{32'h0000_0042, 27'h000002A, 1'b0, 54};
    vecs[5] = '{32'h9000_0000, 27'h55D4A80, 1'b0, 54};
    vecs[6] = '{32'h0000_000F, 27'h0000000, 1'b1, 1};
    vecs[7] = '{32'h8765_4321, 27'h5397FB1, 1'b0, 54};

    // Reset state
    rst   = 1'b1;
    start = 1'b0;
    set_bcd(32'h0);
    #12;
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset binary", {5'd0, binary_value}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven operands
    for (int i = 0; i < 8; i++) begin
      run_convert(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // start pulsed at edges 10 and 30 of a conversion must be ignored
    set_bcd(32'h1234_5678);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; dcnt = 0; rcnt = 0; d1 = -1;
    while (n < 70) begin
      if (done) begin
        dcnt++;
        if (d1 < 0) d1 = n;
      end
      if (ready && n <= 54) rcnt++;
      if (n == 9 || n == 29) start = 1'b1;
      if (n == 10 || n == 30) start = 1'b0;
      @(posedge clk); #1; n++;
    end
    check("ignored start: done count", dcnt, 1);
    check("ignored start: done edge", d1, 54);
    check("ignored start: ready low", rcnt, 0);
    check("ignored start: result", {5'd0, binary_value}, {5'd0, 27'h0BC614E});

    // Async reset mid-ADJUST discards the conversion
    set_bcd(32'h1234_5678);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst ready", {31'd0, ready}, 32'd1);
    check("async rst binary", {5'd0, binary_value}, 32'd0);
    check("async rst err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("no done after rst", dcnt, 0);
    run_convert(32'h0000_0042, 27'h2A, 1'b0, 54);

    // start held high: back-to-back conversions of 1
    set_bcd(32'h0000_0001);
    start = 1'b1;
    @(posedge clk); #1;
    n = 1; dcnt = 0; rcnt = 0; d1 = -1; d2 = -1;
    while (n < 130) begin
      if (done) begin
        dcnt++;
        check("back-to-back result", {5'd0, binary_value}, 32'd1);
        if (d1 < 0) d1 = n;
        else if (d2 < 0) begin
          d2 = n;
          start = 1'b0;
        end
      end
      if (ready && d1 >= 0 && d2 < 0) rcnt++;
      @(posedge clk); #1; n++;
    end
    check("back-to-back done count", dcnt, 2);
    check("back-to-back spacing", d2 - d1 + 1, 56);
    check("back-to-back ready cycles", rcnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
